// File: rtl/btn_conditioner_pkg.sv
// Shared types and default timing constants for the button conditioner.
// Build option: BTN_AUTOREPEAT_EN enables hold-to-auto-repeat.
package btn_conditioner_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESS_CHK = 3'd1,
        HELD      = 3'd2,
        REPEAT    = 3'd3,
        REL_CHK   = 3'd4
    } btn_state_e;

    localparam int TICK_DIV_DEF     = 1000;
    localparam int DEB_TICKS_DEF    = 16;
    localparam int REPEAT_DELAY_DEF = 500;
    localparam int REPEAT_RATE_DEF  = 100;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button: 2-flop synchroniser, debounce/repeat FSM with a saturating tick counter.
// Build option: BTN_AUTOREPEAT_EN adds the REPEAT state.
module btn_channel
    import btn_conditioner_pkg::*;
#(
    parameter int DEB_TICKS    = DEB_TICKS_DEF,
    parameter int REPEAT_DELAY = REPEAT_DELAY_DEF,
    parameter int REPEAT_RATE  = REPEAT_RATE_DEF,
    parameter int CNT_W        = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    input  logic tick,
    output logic btn_pulse,
    output logic btn_level
);

    // Ceiling is the largest value any compare needs, so the counter never wraps.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(max3(DEB_TICKS, REPEAT_DELAY, REPEAT_RATE));

    logic             sync1_q, sync2_q, s_btn;
    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             pulse_q, pulse_d;
    logic             level_q, level_d;

    assign s_btn = sync2_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        level_d = level_q;
        cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        case (state_q)
            IDLE: begin
                level_d = 1'b0;
                if (s_btn) begin
                    cnt_d   = '0;
                    state_d = PRESS_CHK;
                end
            end
            PRESS_CHK: begin
                if (!s_btn) begin
                    state_d = IDLE;
                end else if (tick) begin
                    if (cnt_inc == CNT_W'(DEB_TICKS)) begin
                        state_d = HELD;
                        level_d = 1'b1;
                        pulse_d = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            HELD: begin
                if (!s_btn) begin
                    cnt_d   = '0;
                    state_d = REL_CHK;
                end else if (tick) begin
`ifdef BTN_AUTOREPEAT_EN
                    if (cnt_inc == CNT_W'(REPEAT_DELAY)) begin
                        pulse_d = 1'b1;
                        cnt_d   = '0;
                        state_d = REPEAT;
                    end else begin
                        cnt_d = cnt_inc;
                    end
`else
                    cnt_d = cnt_inc;
`endif
                end
            end
`ifdef BTN_AUTOREPEAT_EN
            REPEAT: begin
                if (!s_btn) begin
                    cnt_d   = '0;
                    state_d = REL_CHK;
                end else if (tick) begin
                    if (cnt_inc == CNT_W'(REPEAT_RATE)) begin
                        pulse_d = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
`endif
            REL_CHK: begin
                // A bounce back to pressed restarts the repeat delay without a pulse.
                if (s_btn) begin
                    cnt_d   = '0;
                    state_d = HELD;
                end else if (tick) begin
                    if (cnt_inc == CNT_W'(DEB_TICKS)) begin
                        state_d = IDLE;
                        level_d = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            level_q <= 1'b0;
        end else begin
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            level_q <= level_d;
        end
    end

    assign btn_pulse = pulse_q;
    assign btn_level = level_q;

endmodule

// File: rtl/btn_conditioner.sv
// Shared tick prescaler feeding DIGITS independent button channels.
// Build option: BTN_AUTOREPEAT_EN enables hold-to-auto-repeat in every channel.
module btn_conditioner
    import btn_conditioner_pkg::*;
#(
    parameter int DIGITS       = 2,
    parameter int TICK_DIV     = TICK_DIV_DEF,
    parameter int TICK_W       = 10,
    parameter int DEB_TICKS    = DEB_TICKS_DEF,
    parameter int REPEAT_DELAY = REPEAT_DELAY_DEF,
    parameter int REPEAT_RATE  = REPEAT_RATE_DEF,
    parameter int CNT_W        = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DIGITS-1:0] btn_in,
    output logic [DIGITS-1:0] btn_pulse,
    output logic [DIGITS-1:0] btn_level,
    output logic              tick_out
);

    logic [TICK_W-1:0] pre_q, pre_d;
    logic              tick;

    assign tick  = (pre_q == TICK_W'(TICK_DIV - 1));
    assign pre_d = tick ? '0 : pre_q + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pre_q <= '0;
        else       pre_q <= pre_d;
    end

    assign tick_out = tick;

    for (genvar g = 0; g < DIGITS; g++) begin : g_ch
        btn_channel #(
            .DEB_TICKS   (DEB_TICKS),
            .REPEAT_DELAY(REPEAT_DELAY),
            .REPEAT_RATE (REPEAT_RATE),
            .CNT_W       (CNT_W)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .btn_in   (btn_in[g]),
            .tick     (tick),
            .btn_pulse(btn_pulse[g]),
            .btn_level(btn_level[g])
        );
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Randomised and directed bench for btn_conditioner against a run-length reference model.
// Follows BTN_AUTOREPEAT_EN as compiled.
module tb_btn_conditioner;

    localparam int DIGITS = 2;
    localparam int TDIV   = 4;
    localparam int DEB    = 3;
    localparam int RDLY   = 10;
    localparam int RRATE  = 4;
`ifdef BTN_AUTOREPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [DIGITS-1:0] btn_in = '0;
    logic [DIGITS-1:0] btn_pulse, btn_level;
    logic              tick_out;

    btn_conditioner #(
        .DIGITS(DIGITS), .TICK_DIV(TDIV), .TICK_W(3), .DEB_TICKS(DEB),
        .REPEAT_DELAY(RDLY), .REPEAT_RATE(RRATE), .CNT_W(4)
    ) dut (
        .clk(clk), .reset(reset), .btn_in(btn_in),
        .btn_pulse(btn_pulse), .btn_level(btn_level), .tick_out(tick_out)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: the debounced level flips once the synchronised input
    // has disagreed with it, unchanged, for DEB ticks; while held, pulses come
    // after RDLY ticks and then every RRATE ticks of unchanged pressed input.
    logic [DIGITS-1:0] m_s1, m_s2, m_ps;
    int                m_pre;
    bit                m_lvl [DIGITS];
    int                m_run [DIGITS];
    int                m_rep [DIGITS];
    int                m_gap [DIGITS];
    logic [DIGITS-1:0] exp_pulse, exp_level;
    logic              exp_tick;

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_ps = '0; m_pre = 0;
        for (int i = 0; i < DIGITS; i++) begin
            m_lvl[i] = 1'b0; m_run[i] = 0; m_rep[i] = 0; m_gap[i] = RDLY;
        end
        exp_pulse = '0; exp_level = '0; exp_tick = 1'b0;
    endtask

    task automatic model_edge();
        bit tk;
        bit s, ps, p;
        tk = (m_pre == TDIV - 1);
        for (int i = 0; i < DIGITS; i++) begin
            s = m_s2[i]; ps = m_ps[i]; p = 1'b0;
            if (s != m_lvl[i]) begin
                m_rep[i] = 0; m_gap[i] = RDLY;
                if (s != ps) m_run[i] = 0;
                else if (tk) begin
                    m_run[i]++;
                    if (m_run[i] == DEB) begin
                        m_lvl[i] = s; m_run[i] = 0; p = s;
                    end
                end
            end else begin
                m_run[i] = 0;
                if (REP_EN && m_lvl[i] && s == ps && tk) begin
                    m_rep[i]++;
                    if (m_rep[i] == m_gap[i]) begin
                        p = 1'b1; m_rep[i] = 0; m_gap[i] = RRATE;
                    end
                end
            end
            exp_pulse[i] = p;
            exp_level[i] = m_lvl[i];
        end
        m_ps = m_s2; m_s2 = m_s1; m_s1 = btn_in;
        m_pre = (m_pre + 1) % TDIV;
        exp_tick = (m_pre == TDIV - 1);
    endtask

    task automatic step();
        @(posedge clk);
        if (reset) model_reset();
        else       model_edge();
        #1;
        check("pulse", btn_pulse, exp_pulse);
        check("level", btn_level, exp_level);
        check("tick",  tick_out,  exp_tick);
    endtask

    task automatic settle();
        btn_in = '0;
        repeat (40) step();
    endtask

    initial begin
        int np, lat, lvl_low, first, prev;
        int pt[$];
        bit seen;
        int dur [DIGITS];
        model_reset();

        // Reset held with both buttons pressed: outputs stay zero.
        btn_in = 2'b11;
        repeat (6) step();
        check("rst_out_zero", {btn_pulse, btn_level, tick_out}, 0);
        reset = 1'b0;
        lat = 0;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            step();
            if (btn_pulse[0]) lat = k;
        end
        check("rst_first_pulse_in_window", (lat >= 2 + (DEB - 1) * TDIV && lat <= 2 + DEB * TDIV + 1 + TDIV), 1);
        settle();

        // Bounce on channel 0, then stable press.
        np = 0;
        for (int k = 0; k < 30; k++) begin
            if (k % 3 == 0) btn_in[0] = ~btn_in[0];
            step();
            np += btn_pulse[0];
        end
        check("bounce_no_pulse", np, 0);
        btn_in[0] = 1'b1;
        np = 0;
        repeat (30) begin step(); np += btn_pulse[0]; end
        check("bounce_one_pulse", np, 1);
        check("bounce_level", btn_level[0], 1);

        // Short release glitch while held: level stays, no pulse, repeat delay restarts.
        btn_in[0] = 1'b0;
        np = 0; lvl_low = 0;
        repeat (5) begin step(); np += btn_pulse[0]; lvl_low += !btn_level[0]; end
        btn_in[0] = 1'b1;
        repeat (38) begin step(); np += btn_pulse[0]; lvl_low += !btn_level[0]; end
        check("glitch_no_pulse", np, 0);
        check("glitch_level_kept", lvl_low, 0);
        settle();

        // Long hold on channel 1.
        btn_in[1] = 1'b1;
        pt.delete();
        for (int k = 0; k < 200; k++) begin
            step();
            if (btn_pulse[1]) pt.push_back(k);
        end
        if (REP_EN) begin
            check("repeat_count_ge3", pt.size() >= 3, 1);
            if (pt.size() >= 3) begin
                check("repeat_first_gap", pt[1] - pt[0], RDLY * TDIV);
                for (int j = 2; j < pt.size(); j++)
                    check("repeat_rate_gap", pt[j] - pt[j-1], RRATE * TDIV);
            end
        end else begin
            check("hold_single_pulse", pt.size(), 1);
        end
        settle();

        // Simultaneous press.
        btn_in = 2'b11;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            step();
            if (btn_pulse != 0) begin
                seen = 1'b1;
                check("simul_pulse", btn_pulse, 2'b11);
            end
        end
        check("simul_seen", seen, 1);
        settle();

        // Reset mid-press drops the pending pulse; a full debounce follows.
        btn_in[0] = 1'b1;
        repeat (9) step();
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        first = -1;
        for (int k = 0; k < 40; k++) begin
            step();
            if (btn_pulse[0] && first < 0) first = k + 1;
        end
        check("midrst_full_debounce", first >= 2 + (DEB - 1) * TDIV, 1);
        settle();

        // Random levels and durations on both channels.
        for (int i = 0; i < DIGITS; i++) dur[i] = 0;
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (dur[i] == 0) begin
                    btn_in[i] = 1'($urandom_range(0, 1));
                    dur[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6))
                                                          : int'($urandom_range(8, 90));
                end
                dur[i]--;
            end
            step();
        end
        prev = total;
        settle();
        check("random_ran", total > prev, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
